execute_stage: RTL and testbench



---
 rtl/execute_stage.sv | 165 ++++++++++++++++
 tb/tb_execute_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// execute_stage: execute stage of the 16-bit five-stage pipeline.
// Computes the ALU result or the load/store effective address and registers
// it together with store data and destination-register fields for memory
// access. Define EXECUTE_MUL_EN to build the 16-cycle shift-add multiplier;
// without it MUL decodes as a bubble and stall_ex is tied low.
module execute_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_id,
  input  logic [3:0]  control_id,
  input  logic [15:0] operand_a_id,
  input  logic [15:0] operand_b_id,
  input  logic [15:0] imm_id,
  input  logic [4:0]  dest_reg_index_id,
  input  logic        dest_reg_write_en_id,
  output logic        stall_ex,
  output logic [3:0]  control_ex,
  output logic [15:0] result_ex,
  output logic [15:0] reg_data_ex,
  output logic [4:0]  dest_reg_index_ex,
  output logic        dest_reg_write_en_ex
);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SHL   = 4'b0101;
  localparam logic [3:0] OP_SHR   = 4'b0110;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_LOAD  = 4'b1100;
  localparam logic [3:0] OP_STORE = 4'b1110;
  localparam logic [3:0] OP_NOP   = 4'b1111;

  // Single-cycle datapath results.
  logic        alu_bubble;
  logic [15:0] alu_result;
  logic        alu_write_en;

  // Multiplier handshake into the output register (tied off when absent).
  logic        mul_busy;
  logic        mul_done;
  logic [15:0] mul_product;
  logic [15:0] mul_reg_data;
  logic [4:0]  mul_index;
  logic        mul_write_en;

  // Decode the single-cycle opcodes; MUL, NOP and unknown codes become bubbles.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned, which would infer a latch.
    alu_bubble   = 1'b0;
    alu_result   = '0;
    alu_write_en = dest_reg_write_en_id;
    case (control_id)
      OP_ADD:   alu_result = operand_a_id + operand_b_id;
      OP_SUB:   alu_result = operand_a_id - operand_b_id;
      OP_AND:   alu_result = operand_a_id & operand_b_id;
      OP_OR:    alu_result = operand_a_id | operand_b_id;
      OP_XOR:   alu_result = operand_a_id ^ operand_b_id;
      OP_SHL:   alu_result = operand_a_id << operand_b_id[3:0];
      OP_SHR:   alu_result = operand_a_id >> operand_b_id[3:0];
      OP_LOAD:  alu_result = operand_a_id + imm_id;
      OP_STORE: begin
        alu_result   = operand_a_id + imm_id;
        alu_write_en = 1'b0;
      end
      default:  alu_bubble = 1'b1;
    endcase
    if (!valid_id) begin
      alu_bubble = 1'b1;
    end
  end

  // Output register: multiply completion, bubble while busy, else the single-cycle result.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      control_ex           <= OP_NOP;
      result_ex            <= '0;
      reg_data_ex          <= '0;
      dest_reg_index_ex    <= '0;
      dest_reg_write_en_ex <= 1'b0;
    end else if (mul_done) begin
      control_ex           <= OP_MUL;
      result_ex            <= mul_product;
      reg_data_ex          <= mul_reg_data;
      dest_reg_index_ex    <= mul_index;
      dest_reg_write_en_ex <= mul_write_en;
    end else if (mul_busy || alu_bubble) begin
      control_ex           <= OP_NOP;
      result_ex            <= '0;
      reg_data_ex          <= '0;
      dest_reg_index_ex    <= '0;
      dest_reg_write_en_ex <= 1'b0;
    end else begin
      control_ex           <= control_id;
      result_ex            <= alu_result;
      reg_data_ex          <= operand_b_id;
      dest_reg_index_ex    <= dest_reg_index_id;
      dest_reg_write_en_ex <= alu_write_en;
    end
  end

`ifdef EXECUTE_MUL_EN
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  logic [0:0]  state;
  logic [3:0]  count;          // multiplier bit consumed this cycle
  logic [15:0] multiplicand;   // a, shifted left one place per step
  logic [15:0] multiplier;     // original b, kept whole for reg_data_ex
  logic [15:0] product;        // running low 16 bits of the product
  logic [15:0] product_next;
  logic        mul_start;

  assign mul_start    = (state == ST_IDLE) && valid_id && (control_id == OP_MUL);
  assign product_next = multiplier[count] ? (product + multiplicand) : product;
  assign mul_busy     = (state == ST_MUL);
  assign mul_done     = mul_busy && (count == 4'd15);
  assign mul_product  = product_next;
  assign mul_reg_data = multiplier;

  // Multiplier FSM: latch operands in IDLE, then one shift-add step per cycle for 16 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      count        <= '0;
      multiplicand <= '0;
      multiplier   <= '0;
      product      <= '0;
      mul_index    <= '0;
      mul_write_en <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (mul_start) begin
        state        <= ST_MUL;
        count        <= '0;
        product      <= '0;
        multiplicand <= operand_a_id;
        multiplier   <= operand_b_id;
        mul_index    <= dest_reg_index_id;
        mul_write_en <= dest_reg_write_en_id;
      end
    end else begin
      product      <= product_next;
      multiplicand <= multiplicand << 1;
      count        <= count + 4'd1;
      if (count == 4'd15) begin
        state <= ST_IDLE;
      end
    end
  end
`else
  assign mul_busy     = 1'b0;
  assign mul_done     = 1'b0;
  assign mul_product  = '0;
  assign mul_reg_data = '0;
  assign mul_index    = '0;
  assign mul_write_en = 1'b0;
`endif

  // Stall is a pure decode of the registered FSM state.
  assign stall_ex = mul_busy;

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed bench for execute_stage with a cycle-level
// behavioural model compared on every falling edge, plus literal checks.
// Works with and without EXECUTE_MUL_EN defined.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_id = 1'b0;
  logic [3:0]  control_id = 4'hF;
  logic [15:0] operand_a_id = '0;
  logic [15:0] operand_b_id = '0;
  logic [15:0] imm_id = '0;
  logic [4:0]  dest_reg_index_id = '0;
  logic        dest_reg_write_en_id = 1'b0;
  logic        stall_ex;
  logic [3:0]  control_ex;
  logic [15:0] result_ex;
  logic [15:0] reg_data_ex;
  logic [4:0]  dest_reg_index_ex;
  logic        dest_reg_write_en_ex;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  execute_stage dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .valid_id             (valid_id),
    .control_id           (control_id),
    .operand_a_id         (operand_a_id),
    .operand_b_id         (operand_b_id),
    .imm_id               (imm_id),
    .dest_reg_index_id    (dest_reg_index_id),
    .dest_reg_write_en_id (dest_reg_write_en_id),
    .stall_ex             (stall_ex),
    .control_ex           (control_ex),
    .result_ex            (result_ex),
    .reg_data_ex          (reg_data_ex),
    .dest_reg_index_ex    (dest_reg_index_ex),
    .dest_reg_write_en_ex (dest_reg_write_en_ex)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0]  m_control  = 4'hF;
  logic [15:0] m_result   = '0;
  logic [15:0] m_reg_data = '0;
  logic [4:0]  m_index    = '0;
  logic        m_we       = 1'b0;
  logic        m_stall    = 1'b0;
  int          m_mul_left = 0;   // edges until the product appears
  logic [15:0] m_a, m_b;
  logic [4:0]  m_idx;
  logic        m_mwe;

  task automatic model_bubble();
    m_control  <= 4'hF;
    m_result   <= '0;
    m_reg_data <= '0;
    m_index    <= '0;
    m_we       <= 1'b0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_bubble();
      m_stall    <= 1'b0;
      m_mul_left <= 0;
    end else if (m_mul_left > 1) begin
      model_bubble();
      m_mul_left <= m_mul_left - 1;
    end else if (m_mul_left == 1) begin
      m_control  <= 4'b1000;
      m_result   <= 16'(m_a * m_b);
      m_reg_data <= m_b;
      m_index    <= m_idx;
      m_we       <= m_mwe;
      m_stall    <= 1'b0;
      m_mul_left <= 0;
    end else if (!valid_id) begin
      model_bubble();
    end else begin
      m_control  <= control_id;
      m_reg_data <= operand_b_id;
      m_index    <= dest_reg_index_id;
      m_we       <= dest_reg_write_en_id;
      case (control_id)
        4'b0000: m_result <= operand_a_id + operand_b_id;
        4'b0001: m_result <= operand_a_id - operand_b_id;
        4'b0010: m_result <= operand_a_id & operand_b_id;
        4'b0011: m_result <= operand_a_id | operand_b_id;
        4'b0100: m_result <= operand_a_id ^ operand_b_id;
        4'b0101: m_result <= operand_a_id << operand_b_id[3:0];
        4'b0110: m_result <= operand_a_id >> operand_b_id[3:0];
        4'b1100: m_result <= operand_a_id + imm_id;
        4'b1110: begin
          m_result <= operand_a_id + imm_id;
          m_we     <= 1'b0;
        end
`ifdef EXECUTE_MUL_EN
        4'b1000: begin
          model_bubble();
          m_stall    <= 1'b1;
          m_mul_left <= 16;
          m_a        <= operand_a_id;
          m_b        <= operand_b_id;
          m_idx      <= dest_reg_index_id;
          m_mwe      <= dest_reg_write_en_id;
        end
`endif
        default: model_bubble();
      endcase
    end
  end

  // Every-cycle comparison of DUT against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check("cmp_control", 16'(control_ex), 16'(m_control));
      check("cmp_result", result_ex, m_result);
      check("cmp_reg_data", reg_data_ex, m_reg_data);
      check("cmp_index", 16'(dest_reg_index_ex), 16'(m_index));
      check("cmp_we", 16'(dest_reg_write_en_ex), 16'(m_we));
      check("cmp_stall", 16'(stall_ex), 16'(m_stall));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] imm,
                       input logic [4:0] idx, input logic we);
    valid_id             = v;
    control_id           = op;
    operand_a_id         = a;
    operand_b_id         = b;
    imm_id               = imm;
    dest_reg_index_id    = idx;
    dest_reg_write_en_id = we;
  endtask

  task automatic check_bubble(input string name);
    check({name, "_control"}, 16'(control_ex), 16'h000F);
    check({name, "_result"}, result_ex, 16'h0000);
    check({name, "_reg_data"}, reg_data_ex, 16'h0000);
    check({name, "_index"}, 16'(dest_reg_index_ex), 16'h0000);
    check({name, "_we"}, 16'(dest_reg_write_en_ex), 16'h0000);
    check({name, "_stall"}, 16'(stall_ex), 16'h0000);
  endtask

  int n_stall;

  initial begin
    // Reset held for a few cycles.
    repeat (3) @(negedge clk);
    check_bubble("reset_hold");
    rst_n = 1'b1;
    check_en = 1'b1;

    // ALU sweep with literal expectations.
    drive(1, 4'b0000, 16'hFFFF, 16'h0002, 16'h0000, 5'd3, 1);
    @(negedge clk);
    check("add_wrap", result_ex, 16'h0001);
    check("add_we", 16'(dest_reg_write_en_ex), 16'h0001);
    check("add_index", 16'(dest_reg_index_ex), 16'h0003);
    drive(1, 4'b0001, 16'h0000, 16'h0001, 16'h0000, 5'd4, 1);
    @(negedge clk);
    check("sub_wrap", result_ex, 16'hFFFF);
    drive(1, 4'b0110, 16'h8000, 16'h000F, 16'h0000, 5'd5, 1);
    @(negedge clk);
    check("shr_15", result_ex, 16'h0001);
    drive(1, 4'b0101, 16'h0001, 16'h0014, 16'h0000, 5'd6, 1);
    @(negedge clk);
    check("shl_low_bits", result_ex, 16'h0010);
    drive(1, 4'b0010, 16'hF0F0, 16'hFF00, 16'h0000, 5'd7, 0);
    @(negedge clk);
    check("and_no_we", 16'(dest_reg_write_en_ex), 16'h0000);
    drive(1, 4'b0011, 16'hF0F0, 16'h0F0F, 16'h0000, 5'd8, 1);
    @(negedge clk);
    drive(1, 4'b0100, 16'hAAAA, 16'hFFFF, 16'h0000, 5'd9, 1);
    @(negedge clk);
    check("xor", result_ex, 16'h5555);

    // STORE: address wraps, store data forwarded, write enable forced off.
    drive(1, 4'b1110, 16'h1000, 16'hBEEF, 16'hFFFE, 5'd10, 1);
    @(negedge clk);
    check("store_addr", result_ex, 16'h0FFE);
    check("store_data", reg_data_ex, 16'hBEEF);
    check("store_we", 16'(dest_reg_write_en_ex), 16'h0000);
    check("store_control", 16'(control_ex), 16'h000E);

    drive(1, 4'b1100, 16'h0010, 16'h1234, 16'hFFF0, 5'd11, 1);
    @(negedge clk);
    check("load_addr", result_ex, 16'h0000);
    check("load_we", 16'(dest_reg_write_en_ex), 16'h0001);

    // Bubbles: no valid, explicit NOP, unknown opcode.
    drive(0, 4'b0000, 16'h1111, 16'h2222, 16'h0000, 5'd12, 1);
    @(negedge clk);
    check_bubble("invalid");
    drive(1, 4'b0111, 16'h1111, 16'h2222, 16'h0000, 5'd13, 1);
    @(negedge clk);
    check_bubble("unknown_op");
    drive(1, 4'b1111, 16'h1111, 16'h2222, 16'h0000, 5'd14, 1);
    @(negedge clk);

    // Asynchronous reset dropped mid-cycle.
    drive(1, 4'b0000, 16'h0100, 16'h0200, 16'h0000, 5'd15, 1);
    @(negedge clk);
    check("pre_reset_add", result_ex, 16'h0300);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_bubble("async_reset");
    @(negedge clk);
    rst_n = 1'b1;

`ifdef EXECUTE_MUL_EN
    // Multiply, with the following ADD held during the stall.
    drive(1, 4'b1000, 16'h0123, 16'h0456, 16'h0000, 5'd20, 1);
    @(negedge clk);
    check("mul_accept_bubble", 16'(control_ex), 16'h000F);
    drive(1, 4'b0000, 16'h0003, 16'h0004, 16'h0000, 5'd21, 1);
    n_stall = 0;
    while (stall_ex && n_stall < 40) begin
      n_stall++;
      @(negedge clk);
    end
    check("mul_stall_cycles", 16'(n_stall), 16'd16);
    check("mul_result", result_ex, 16'hEDC2);
    check("mul_control", 16'(control_ex), 16'h0008);
    check("mul_reg_data", reg_data_ex, 16'h0456);
    check("mul_index", 16'(dest_reg_index_ex), 16'd20);
    @(negedge clk);
    check("held_add", result_ex, 16'h0007);
    check("held_add_index", 16'(dest_reg_index_ex), 16'd21);
`else
    // Without the multiplier, MUL is a plain bubble and never stalls.
    drive(1, 4'b1000, 16'h0123, 16'h0456, 16'h0000, 5'd20, 1);
    @(negedge clk);
    check_bubble("mul_disabled");
    drive(1, 4'b0000, 16'h0003, 16'h0004, 16'h0000, 5'd21, 1);
    @(negedge clk);
    check("after_mul_add", result_ex, 16'h0007);
`endif

    // Reset while a multiply is at count 7, then resume normally.
    drive(1, 4'b1000, 16'h00FF, 16'h00FF, 16'h0000, 5'd22, 1);
    @(negedge clk);
    drive(1, 4'b0000, 16'h0005, 16'h0006, 16'h0000, 5'd23, 1);
    repeat (7) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_bubble("mul_abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_abort_add", result_ex, 16'h000B);
    check("post_abort_stall", 16'(stall_ex), 16'h0000);

    drive(0, 4'b1111, 16'h0000, 16'h0000, 16'h0000, 5'd0, 0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
